// File: rtl/adder_sequencer.sv
// adder_sequencer
//   AXI4-Lite-style master that runs one addition on a memory-mapped adder
//   slave: write A @+0x0, write B @+0x4, read sum @+0x8, read overflow @+0xC,
//   then hands {sum, ovf, err} back on a valid/ready result port.
//
// Ports
//   m1_axi_aclk / m1_axi_areset   clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_opa/cmd_opb         operand command port
//   res_valid/res_ready, res_sum/res_ovf/res_err result port
//   m1_axi_aw*/w*/b*   write address/data/response channels
//   m1_axi_ar*/r*      read address/data channels
//   (bresp/rresp are 1 bit: 1 = OK, 0 = error)
//
// Build option
//   ADDER_SEQ_TIMEOUT_EN : per-state watchdog; a handshake that stalls for
//   TIMEOUT_CYC cycles aborts the transaction with err=1, sum=0, ovf=0.
module adder_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_opa,
  input  logic [DATA_WIDTH-1:0]   cmd_opb,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_sum,
  output logic                    res_ovf,
  output logic                    res_err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8:0]   m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] OFF_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OFF_B = ADDR_WIDTH'(BASE_ADDR + 4);
  localparam logic [ADDR_WIDTH-1:0] OFF_S = ADDR_WIDTH'(BASE_ADDR + 8);
  localparam logic [ADDR_WIDTH-1:0] OFF_O = ADDR_WIDTH'(BASE_ADDR + 12);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WB_A, S_WR_B, S_WB_B, S_RD_S, S_RD_O, S_DONE
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_opb;
  logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_sum;
  logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                    r_aw_done, r_w_done, r_b_done;
  logic                    r_ovf, r_err, r_res_valid, r_cmd_ready;

  logic w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
  logic w_aw_seen, w_w_seen, w_tmo;

  assign w_aw_fire = r_awvalid & m1_axi_awready;
  assign w_w_fire  = r_wvalid  & m1_axi_wready;
  assign w_b_fire  = r_bready  & m1_axi_bvalid;
  assign w_ar_fire = r_arvalid & m1_axi_arready;
  assign w_r_fire  = r_rready  & m1_axi_rvalid;
  assign w_aw_seen = r_aw_done | w_aw_fire;
  assign w_w_seen  = r_w_done  | w_w_fire;

`ifdef ADDER_SEQ_TIMEOUT_EN
  // Counter restarts whenever the state changes; the equality term in w_tmo
  // masks the one cycle where the count still belongs to the previous state.
  logic [15:0] r_tmo_cnt;
  state_t      r_state_q;

  always_ff @(posedge m1_axi_aclk) begin
    if (m1_axi_areset) begin
      r_tmo_cnt <= '0;
      r_state_q <= S_IDLE;
    end else begin
      r_state_q <= r_state;
      if (r_state != r_state_q) r_tmo_cnt <= '0;
      else if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_tmo = (r_state != S_IDLE) && (r_state != S_DONE) &&
                 (r_state == r_state_q) && (r_tmo_cnt >= 16'(TIMEOUT_CYC));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge m1_axi_aclk) begin
    if (m1_axi_areset) begin
      r_state     <= S_IDLE;
      r_opb       <= '0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_sum       <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else if (w_tmo) begin
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_err       <= 1'b1;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_res_valid <= 1'b1;
      r_state     <= S_DONE;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_opb       <= cmd_opb;
          r_awaddr    <= OFF_A;
          r_wdata     <= cmd_opa;
          r_awvalid   <= 1'b1;
          r_wvalid    <= 1'b1;
          r_bready    <= 1'b1;
          r_aw_done   <= 1'b0;
          r_w_done    <= 1'b0;
          r_b_done    <= 1'b0;
          r_err       <= 1'b0;
          r_sum       <= '0;
          r_ovf       <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= S_WR_A;
        end
        S_WR_A, S_WR_B: begin
          if (w_aw_fire) begin r_awvalid <= 1'b0; r_aw_done <= 1'b1; end
          if (w_w_fire)  begin r_wvalid  <= 1'b0; r_w_done  <= 1'b1; end
          if (w_b_fire) begin
            // Response already consumed here; WB_x must not wait for another.
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_b_done  <= 1'b1;
            if (!m1_axi_bresp) r_err <= 1'b1;
            r_state <= (r_state == S_WR_A) ? S_WB_A : S_WB_B;
          end else if (w_aw_seen && w_w_seen) begin
            r_state <= (r_state == S_WR_A) ? S_WB_A : S_WB_B;
          end
        end
        S_WB_A, S_WB_B: if (r_b_done || w_b_fire) begin
          if (w_b_fire && !m1_axi_bresp) r_err <= 1'b1;
          r_b_done <= 1'b0;
          if (r_state == S_WB_A) begin
            r_awaddr  <= OFF_B;
            r_wdata   <= r_opb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_WR_B;
          end else begin
            r_bready  <= 1'b0;
            r_araddr  <= OFF_S;
            r_arvalid <= 1'b1;
            r_rready  <= 1'b1;
            r_state   <= S_RD_S;
          end
        end
        S_RD_S, S_RD_O: begin
          // rvalid implies the address was taken even if arready was missed
          if (w_ar_fire || w_r_fire) r_arvalid <= 1'b0;
          if (w_r_fire) begin
            if (!m1_axi_rresp) r_err <= 1'b1;
            if (r_state == S_RD_S) begin
              r_sum     <= m1_axi_rdata;
              r_araddr  <= OFF_O;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_O;
            end else begin
              r_ovf       <= m1_axi_rdata[0];
              r_rready    <= 1'b0;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: if (res_ready) begin
          r_res_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign res_valid      = r_res_valid;
  assign res_sum        = r_sum;
  assign res_ovf        = r_ovf;
  assign res_err        = r_err;
  assign m1_axi_awaddr  = r_awaddr;
  assign m1_axi_awvalid = r_awvalid;
  assign m1_axi_wdata   = r_wdata;
  assign m1_axi_wstrb   = '1;
  assign m1_axi_wvalid  = r_wvalid;
  assign m1_axi_bready  = r_bready;
  assign m1_axi_araddr  = r_araddr;
  assign m1_axi_arvalid = r_arvalid;
  assign m1_axi_rready  = r_rready;

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: behavioural AXI-Lite adder slave with
// programmable AW/W ready delays, queue scoreboard checked by a result monitor.
module tb_adder_sequencer;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_opa, cmd_opb;
  logic          res_valid, res_ready, res_ovf, res_err;
  logic [DW-1:0] res_sum;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic          arvalid, arready, rresp, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8:0] wstrb;

  adder_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0), .TIMEOUT_CYC(255)) dut (
    .m1_axi_aclk(clk), .m1_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_ovf(res_ovf),
    .res_err(res_err),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  // ---------------- slave model ----------------
  int            aw_dly = 0, w_dly = 0, aw_wait, w_wait, aw_hi, w_hi;
  int            wr_cnt [4];
  logic          bresp_val = 1'b1, rvalid_off = 1'b0;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_q, s_a;
  logic [DW-1:0] w_q, s_d, rega, regb;
  logic [DW:0]   s_sum;
  logic [AW-1:0] addr_log [$];

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid && (w_wait >= w_dly);
  assign arready = 1'b1;
  assign bresp   = bresp_val;
  assign rresp   = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_q <= '0; w_q <= '0; bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
    end else begin
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid)  w_hi  <= w_hi + 1;
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_q <= awaddr; aw_wait <= 0;
        addr_log.push_back(awaddr);
        wr_cnt[awaddr[3:2]] <= wr_cnt[awaddr[3:2]] + 1;
      end else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; w_q <= wdata; w_wait <= 0;
      end else if (wvalid) w_wait <= w_wait + 1;
      s_a = (awvalid && awready) ? awaddr : aw_q;
      s_d = (wvalid && wready) ? wdata : w_q;
      if (bvalid && bready) bvalid <= 1'b0;
      if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        if (s_a == 8'h0) rega <= s_d;
        else if (s_a == 8'h4) regb <= s_d;
        bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        addr_log.push_back(araddr);
        if (!rvalid_off) begin
          s_sum = {1'b0, rega} + {1'b0, regb};
          rvalid <= 1'b1;
          if (araddr == 8'h8) rdata <= s_sum[DW-1:0];
          else if (araddr == 8'hC) rdata <= {{(DW-1){1'b0}}, s_sum[DW]};
          else rdata <= '0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct packed { logic [DW-1:0] s; logic o; logic e; } exp_t;
  exp_t sb [$];
  int   n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("res_sum", res_sum, e.s);
        chk("res_ovf", res_ovf, e.o);
        chk("res_err", res_err, e.e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [DW-1:0] a, b, input bit push,
                       input logic [DW-1:0] es, input logic eo, ee);
    int i = 0;
    while (!cmd_ready && i < 300) begin tick(); i++; end
    if (!cmd_ready) begin chk("cmd_ready_wait", cmd_ready, 1); return; end
    cmd_opa = a; cmd_opb = b; cmd_valid = 1'b1;
    if (push) sb.push_back({es, eo, ee});
    tick();
    acc_cyc = cyc; cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    int i = 0;
    lat = -1;
    while (!res_valid && i < 2000) begin tick(); i++; end
    if (!res_valid) chk("res_valid_wait", res_valid, 1);
    else lat = cyc - acc_cyc;
  endtask

  task automatic wait_clear();
    int i = 0;
    while (res_valid && i < 100) begin tick(); i++; end
    if (res_valid) chk("res_clear_wait", res_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_log, k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_opa = '0; cmd_opb = '0; res_ready = 1'b1;
    aw_hi = 0; w_hi = 0; rega = '0; regb = '0;
    foreach (wr_cnt[j]) wr_cnt[j] = 0;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_sum_ovf_err", {res_sum, res_ovf, res_err}, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("wstrb_ones", wstrb, 5'h1F);
    rst = 1'b0;
    tick();

    // 1) 5+7, zero-wait latency
    issue(32'd5, 32'd7, 1, 32'd12, 1'b0, 1'b0);
    wait_res(lat);
    chk("latency_zero_wait", lat, 8);
    wait_clear();

    // 2) carry out, address order
    addr_log.delete();
    issue(32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b1, 1'b0);
    wait_res(lat);
    wait_clear();
    chk("trace_len", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("trace0", addr_log[0], 8'h0);
      chk("trace1", addr_log[1], 8'h4);
      chk("trace2", addr_log[2], 8'h8);
      chk("trace3", addr_log[3], 8'hC);
    end

    // 3) delayed awready/wready: independent drop, one write per address
    aw_dly = 3; w_dly = 5;
    tick();
    k = aw_hi; n_log = w_hi;
    foreach (wr_cnt[j]) wr_cnt[j] = 0;
    issue(32'h1234_5678, 32'h1111_1111, 1, 32'h2345_6789, 1'b0, 1'b0);
    wait_res(lat);
    wait_clear();
    chk("aw_high_cycles", aw_hi - k, 8);
    chk("w_high_cycles", w_hi - n_log, 12);
    chk("writes_at_0", wr_cnt[0], 1);
    chk("writes_at_4", wr_cnt[1], 1);
    aw_dly = 0; w_dly = 0;

    // 4) result backpressure; cmd pulse ignored
    res_ready = 1'b0;
    addr_log.delete();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_res(lat);
    for (int c = 0; c < 10; c++) begin
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_sum", res_sum, 32'hFFFF_FFFE);
      chk("hold_res_ovf", res_ovf, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      if (c == 3) begin cmd_opa = 32'd9; cmd_opb = 32'd9; cmd_valid = 1'b1; end
      if (c == 4) cmd_valid = 1'b0;
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("b2b_cmd_ready", cmd_ready, 1);
    repeat (6) tick();
    chk("pulse_ignored_log", addr_log.size(), 4);
    chk("pulse_ignored_awvalid", awvalid, 0);

    // 5) reset while in RD_S, then fresh command
    issue(32'd1, 32'd1, 0, 32'd0, 1'b0, 1'b0);
    k = 0;
    while (!(arvalid && araddr == 8'h8) && k < 200) begin tick(); k++; end
    chk("reach_rd_s", arvalid && araddr == 8'h8, 1);
    rst = 1'b1;
    tick();
    chk("abort_valids", {awvalid, wvalid, arvalid, res_valid, bready, rready}, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();
    issue(32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0);
    wait_res(lat);
    chk("latency_after_reset", lat, 8);
    wait_clear();

    // bresp error flags err, sum still transferred
    bresp_val = 1'b0;
    issue(32'd3, 32'd4, 1, 32'd7, 1'b0, 1'b1);
    wait_res(lat);
    wait_clear();
    bresp_val = 1'b1;

`ifdef ADDER_SEQ_TIMEOUT_EN
    // 6) read data never arrives
    rvalid_off = 1'b1;
    issue(32'd1, 32'd2, 1, 32'd0, 1'b0, 1'b1);
    wait_res(lat);
    chk("timeout_arvalid", arvalid, 0);
    wait_clear();
    rvalid_off = 1'b0;
`endif

    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
